// File: rtl/cam_ctrl_pkg.sv
// Shared types and constants for the CAM lookup-or-learn controller.
package cam_ctrl_pkg;

  localparam int unsigned KEY_W = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned IDX_W = 4;

  localparam logic [KEY_W-1:0] RESERVED_KEY = '0;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOOKUP,
    CHECK,
    WRITE,
    RESP
  } state_e;

endpackage

// File: rtl/cam_stat_counter.sv
// 16-bit saturating event counter; only instantiated when CAM_CTRL_STATS_EN is defined.
module cam_stat_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/cam_learn_ctrl.sv
// Lookup-or-learn sequencer for a 16x8 CAM with round-robin victim allocation.
// Optional hit/miss/error counters are enabled by defining CAM_CTRL_STATS_EN.
module cam_learn_ctrl
  import cam_ctrl_pkg::*;
#(
  parameter int unsigned KEY_W = cam_ctrl_pkg::KEY_W,
  parameter int unsigned DEPTH = cam_ctrl_pkg::DEPTH,
  parameter int unsigned IDX_W = cam_ctrl_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [KEY_W-1:0] req_key,
  input  logic             flush,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IDX_W-1:0] rsp_idx,
  output logic             rsp_new,
  output logic             rsp_evict,
  output logic             rsp_err,
  output logic             busy,
  output logic             full,
  output logic             cam_wen,
  output logic             cam_ren,
  output logic [KEY_W-1:0] cam_din,
  output logic [IDX_W-1:0] cam_addr,
  input  logic [IDX_W-1:0] cam_dout,
  input  logic             cam_hit
`ifdef CAM_CTRL_STATS_EN
  ,
  output logic [15:0]      stat_hits,
  output logic [15:0]      stat_misses,
  output logic [15:0]      stat_errs
`endif
);

  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

  state_e           state_q, state_d;
  logic [IDX_W:0]   init_cnt_q, init_cnt_d;
  logic [IDX_W:0]   fill_q, fill_d;
  logic [IDX_W-1:0] victim_q, victim_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDX_W-1:0] rsp_idx_q, rsp_idx_d;
  logic             rsp_new_q, rsp_new_d;
  logic             rsp_evict_q, rsp_evict_d;
  logic             rsp_err_q, rsp_err_d;
  logic             cam_wen_q, cam_wen_d;
  logic             cam_ren_q, cam_ren_d;
  logic [KEY_W-1:0] cam_din_q, cam_din_d;
  logic [IDX_W-1:0] cam_addr_q, cam_addr_d;
  logic             rsp_hs;

  assign rsp_hs    = rsp_valid_q && rsp_ready;
  assign req_ready = (state_q == IDLE) && !flush;
  assign busy      = (state_q != IDLE);
  assign full      = (fill_q == DEPTH_C);

  // CAM strobes are registered from the transition into LOOKUP/WRITE so they
  // line up with that state; rsp_valid trails entry into RESP by one cycle.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    fill_d      = fill_q;
    victim_d    = victim_q;
    key_d       = key_q;
    rsp_valid_d = 1'b0;
    rsp_idx_d   = rsp_idx_q;
    rsp_new_d   = rsp_new_q;
    rsp_evict_d = rsp_evict_q;
    rsp_err_d   = rsp_err_q;
    cam_wen_d   = 1'b0;
    cam_ren_d   = 1'b0;
    cam_din_d   = '0;
    cam_addr_d  = '0;

    case (state_q)
      INIT: begin
        if (init_cnt_q != DEPTH_C) begin
          cam_wen_d  = 1'b1;
          cam_addr_d = init_cnt_q[IDX_W-1:0];
          init_cnt_d = init_cnt_q + 1'b1;
        end else begin
          victim_d = '0;
          fill_d   = '0;
          state_d  = IDLE;
        end
      end
      IDLE: begin
        if (flush) begin
          init_cnt_d = '0;
          state_d    = INIT;
        end else if (req_valid) begin
          key_d       = req_key;
          rsp_idx_d   = '0;
          rsp_new_d   = 1'b0;
          rsp_evict_d = 1'b0;
          rsp_err_d   = 1'b0;
          if (req_key == KEY_W'(RESERVED_KEY)) begin
            rsp_err_d = 1'b1;
            state_d   = RESP;
          end else begin
            cam_ren_d = 1'b1;
            cam_din_d = req_key;
            state_d   = LOOKUP;
          end
        end
      end
      LOOKUP: state_d = CHECK;
      CHECK: begin
        if (cam_hit) begin
          rsp_idx_d = cam_dout;
          rsp_new_d = 1'b0;
          state_d   = RESP;
        end else begin
          cam_wen_d   = 1'b1;
          cam_addr_d  = victim_q;
          cam_din_d   = key_q;
          rsp_idx_d   = victim_q;
          rsp_new_d   = 1'b1;
          rsp_evict_d = full;
          victim_d    = victim_q + 1'b1;
          if (!full) fill_d = fill_q + 1'b1;
          state_d     = WRITE;
        end
      end
      WRITE: state_d = RESP;
      RESP: begin
        if (rsp_hs) begin
          rsp_idx_d   = '0;
          rsp_new_d   = 1'b0;
          rsp_evict_d = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      fill_q      <= '0;
      victim_q    <= '0;
      key_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_new_q   <= 1'b0;
      rsp_evict_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      cam_wen_q   <= 1'b0;
      cam_ren_q   <= 1'b0;
      cam_din_q   <= '0;
      cam_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      fill_q      <= fill_d;
      victim_q    <= victim_d;
      key_q       <= key_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_new_q   <= rsp_new_d;
      rsp_evict_q <= rsp_evict_d;
      rsp_err_q   <= rsp_err_d;
      cam_wen_q   <= cam_wen_d;
      cam_ren_q   <= cam_ren_d;
      cam_din_q   <= cam_din_d;
      cam_addr_q  <= cam_addr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_idx   = rsp_idx_q;
  assign rsp_new   = rsp_new_q;
  assign rsp_evict = rsp_evict_q;
  assign rsp_err   = rsp_err_q;
  assign cam_wen   = cam_wen_q;
  assign cam_ren   = cam_ren_q;
  assign cam_din   = cam_din_q;
  assign cam_addr  = cam_addr_q;

`ifdef CAM_CTRL_STATS_EN
  cam_stat_counter u_stat_hits (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rsp_hs && !rsp_err_q && !rsp_new_q),
    .count (stat_hits)
  );

  cam_stat_counter u_stat_misses (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rsp_hs && rsp_new_q),
    .count (stat_misses)
  );

  cam_stat_counter u_stat_errs (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rsp_hs && rsp_err_q),
    .count (stat_errs)
  );
`endif

endmodule

// File: doc/cam_learn_ctrl.md
# cam_learn_ctrl

Lookup-or-learn controller that sequences the 16×8 content-addressable memory for a single requester. Each request is a key: on a hit it returns the matching index; on a miss it writes the key into a round-robin victim slot and returns that index. It also initialises the CAM after reset or flush, so stale contents never produce false hits. It sits between a valid/ready client and the CAM's `wen`/`ren`/`din`/`addr`/`dout`/`hit` port.

## Interface
- `KEY_W`, 8: key width; must equal CAM data width.
- `DEPTH`, 16: CAM entries; must equal CAM depth.
- `IDX_W`, 4: index width, log2(DEPTH).
- `clk` in 1: the design's single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: client request valid.
- `req_ready` out 1: controller can accept a request.
- `req_key` in KEY_W: key to look up or learn.
- `flush` in 1: re-initialise the CAM; sampled in IDLE only.
- `rsp_valid` out 1: response valid; held until `rsp_ready`.
- `rsp_ready` in 1: client accepts the response.
- `rsp_idx` out IDX_W: matched or allocated index.
- `rsp_new` out 1: key was learned (miss).
- `rsp_evict` out 1: learn overwrote an occupied slot.
- `rsp_err` out 1: key was the reserved value 0; no CAM access.
- `busy` out 1: state is not IDLE.
- `full` out 1: all DEPTH slots have been learned since the last init.
- `cam_wen`, `cam_ren` out 1: CAM write and read strobes.
- `cam_din` out KEY_W: CAM data and search key.
- `cam_addr` out IDX_W: CAM write address.
- `cam_dout` in IDX_W, `cam_hit` in 1: registered CAM result; valid the cycle after `cam_ren`.

## Operation
- **INIT**
  - Drives `cam_wen=1`, `cam_din=0`, `cam_addr=init_cnt` for init_cnt 0..DEPTH-1 (16 cycles).
  - Clears the victim pointer and fill count, then goes to IDLE.
- **IDLE**
  - `req_ready = !flush`.
  - `flush=1` goes to INIT; flush has priority over a request in the same cycle.
  - On `req_valid && req_ready`, registers the key.
  - Key 0 goes to RESP with `rsp_err=1` and `rsp_idx=0`. Any other key goes to LOOKUP.
- **LOOKUP**
  - Drives `cam_ren=1`, `cam_din=key`, then goes to CHECK.
- **CHECK**
  - Samples `cam_hit`/`cam_dout`.
  - Hit: `rsp_idx=cam_dout`, `rsp_new=0`, go to RESP.
  - Miss: go to WRITE.
- **WRITE**
  - Drives `cam_wen=1`, `cam_addr=victim`, `cam_din=key`.
  - Sets `rsp_idx=victim`, `rsp_new=1`, `rsp_evict=full`.
  - victim increments and wraps 15→0; fill count saturates at DEPTH. Then goes to RESP.
- **RESP**
  - `rsp_valid=1` with all response fields stable.
  - On `rsp_ready`, goes to IDLE.
- **Strobe rules**
  - `cam_wen` and `cam_ren` are never both high.
  - Both are 0 in IDLE, CHECK and RESP.
- **Duplicates:** a key is never written while it is already present, so each non-zero key occupies at most one slot.
- **Reset (asserted anytime, including mid-request):**
  - Any in-flight request is dropped, with no response.
  - State = INIT; counters and pointers = 0.
  - All outputs = 0, except `busy=1`.

## Timing
- `req_ready` is combinational from state and `flush`. All other outputs are registered or decoded from state only.
- The first INIT write occurs in the first cycle after `rst_n` deasserts. `req_ready` first rises 16 cycles later.
- Request accepted at edge T:
  - Hit: `rsp_valid` high after edge T+3.
  - Miss: `rsp_valid` high after edge T+4.
  - Error: `rsp_valid` high after edge T+1.
- Back-to-back requests: `rsp_ready` high at edge R allows the next acceptance at edge R+1 at the earliest.
- `full` updates the cycle after the 16th learn. `flush` clears it after INIT completes.

## Configuration
- `CAM_CTRL_STATS_EN` defined:
  - Adds outputs `stat_hits`, `stat_misses`, `stat_errs`, each 16 bits, saturating at 16'hFFFF.
  - Each counts once per response handshake.
  - Cleared by reset only; flush does not clear them.
- Undefined: these ports and counters do not exist.

## Structure
- Package `cam_ctrl_pkg` holds:
  - the state enum (INIT, IDLE, LOOKUP, CHECK, WRITE, RESP);
  - KEY_W, DEPTH, IDX_W;
  - `RESERVED_KEY = 0`.
- Optional sub-module `cam_stat_counter`: a 16-bit saturating counter with increment enable, instantiated three times under the macro.

## Test plan
- Reset release: exactly 16 `cam_wen` pulses, addr 0..15 with din 0, then `req_ready=1`; `rsp_*`=0 throughout.
- Key 8'h3C on an empty CAM → miss, `rsp_idx=0`, `rsp_new=1`, `rsp_evict=0` at T+4. Repeating 8'h3C → hit, `rsp_idx=0`, `rsp_new=0` at T+3.
- Learn 16 distinct keys 1..16 → `full=1`. Key 8'hAA → `rsp_idx=0`, `rsp_evict=1`. Key 1 → miss, `rsp_idx=1`.
- Key 8'h00 → `rsp_err=1` after 1 cycle, no CAM strobe. Hold `rsp_ready=0` for 5 cycles → response stays stable.
- `flush` with `req_valid` in IDLE → INIT runs, request not accepted, `full=0` afterwards. Then key 8'h3C → miss at index 0.
- `rst_n` low during WRITE → no response, INIT reruns. With `CAM_CTRL_STATS_EN`: 2 hits / 3 misses / 1 err give counts 2/3/1.
